weight_loader: RTL and testbench

- Upstream feeder for the local weight memory.
- Accepts 32-bit packed weight words from the DMA/bus read stream over a valid/ready handshake.
- Unpacks each word into two 16-bit weights and issues sequential single-weight writes (write_weight_signal/addr/data) into the weight memory.
- Bounds-checks each load against the memory depth and reports completion to the layer controller.

---
 rtl/weight_loader.sv | 139 +++++++++++++
 tb/tb_weight_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// Unpacks 32-bit packed weight words into two sequential 16-bit weight-memory writes,
// with a range check on each load and a one-cycle completion pulse.
module weight_loader #(
    parameter int MAX_WEIGHT_NUM = 8010,
    parameter int ADDR_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] weight_count,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              write_weight_signal,
    output logic [ADDR_W-1:0] write_weight_addr,
    output logic [15:0]       write_weight_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WR_LO = 3'd2,
        WR_HI = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0] MAX_END = (ADDR_W+1)'(MAX_WEIGHT_NUM);

    state_t            state_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] remaining_r;
    logic [15:0]       hold_hi_r;
    logic [ADDR_W:0]   end_sum_s;
    logic              reject_s;

    // One extra bit so base+count cannot wrap past the memory depth check.
    assign end_sum_s = {1'b0, base_addr} + {1'b0, weight_count};
    assign reject_s  = (weight_count == ADDR_W'(0)) || (end_sum_s > MAX_END);

    // Load sequencer; every output is a register updated alongside the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r             <= IDLE;
            cur_addr_r          <= ADDR_W'(0);
            remaining_r         <= ADDR_W'(0);
            hold_hi_r           <= 16'd0;
            in_ready            <= 1'b0;
            write_weight_signal <= 1'b0;
            write_weight_addr   <= ADDR_W'(0);
            write_weight_data   <= 16'd0;
            busy                <= 1'b0;
            done                <= 1'b0;
            error               <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (reject_s) begin
                            error   <= 1'b1;
                            done    <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            error       <= 1'b0;
                            cur_addr_r  <= base_addr;
                            remaining_r <= weight_count;
                            in_ready    <= 1'b1;
                            busy        <= 1'b1;
                            state_r     <= FETCH;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                FETCH: begin
                    if (in_valid) begin
                        hold_hi_r           <= in_data[31:16];
                        in_ready            <= 1'b0;
                        write_weight_signal <= 1'b1;
                        write_weight_addr   <= cur_addr_r;
                        write_weight_data   <= in_data[15:0];
                        state_r             <= WR_LO;
                    end else begin
                        state_r <= FETCH;
                    end
                end
                WR_LO: begin
                    cur_addr_r  <= cur_addr_r + ADDR_W'(1);
                    remaining_r <= remaining_r - ADDR_W'(1);
                    if (remaining_r == ADDR_W'(1)) begin
                        // Odd count: the high half of the last word is dropped here.
                        write_weight_signal <= 1'b0;
                        write_weight_addr   <= ADDR_W'(0);
                        write_weight_data   <= 16'd0;
                        busy                <= 1'b0;
                        done                <= 1'b1;
                        state_r             <= DONE;
                    end else begin
                        write_weight_addr <= cur_addr_r + ADDR_W'(1);
                        write_weight_data <= hold_hi_r;
                        state_r           <= WR_HI;
                    end
                end
                WR_HI: begin
                    cur_addr_r          <= cur_addr_r + ADDR_W'(1);
                    remaining_r         <= remaining_r - ADDR_W'(1);
                    write_weight_signal <= 1'b0;
                    write_weight_addr   <= ADDR_W'(0);
                    write_weight_data   <= 16'd0;
                    if (remaining_r == ADDR_W'(1)) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        in_ready <= 1'b1;
                        state_r  <= FETCH;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    in_ready            <= 1'b0;
                    write_weight_signal <= 1'b0;
                    write_weight_addr   <= ADDR_W'(0);
                    write_weight_data   <= 16'd0;
                    busy                <= 1'b0;
                    done                <= 1'b0;
                    state_r             <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: hand-computed write sequences, timing offsets,
// range rejection, reset abort and start-while-busy.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] weight_count;
    logic [15:0] base_addr;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        write_weight_signal;
    logic [15:0] write_weight_addr;
    logic [15:0] write_weight_data;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    int e_start = 0;
    int done_cnt = 0;
    int ir_cnt = 0;
    int hs_cnt = 0;
    int wa_q[$];
    int wd_q[$];
    int wo_q[$];

    weight_loader dut (
        .clk                 (clk),
        .rst                 (rst),
        .start               (start),
        .weight_count        (weight_count),
        .base_addr           (base_addr),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_ready            (in_ready),
        .write_weight_signal (write_weight_signal),
        .write_weight_addr   (write_weight_addr),
        .write_weight_data   (write_weight_data),
        .busy                (busy),
        .done                (done),
        .error               (error)
    );

    always #5 clk = ~clk;

    // Edge counter used to time writes relative to the start edge.
    always @(posedge clk) ecnt <= ecnt + 1;

    // Observe outputs mid-cycle and log writes, done pulses and handshakes.
    always @(negedge clk) begin
        if (write_weight_signal) begin
            wa_q.push_back(int'(write_weight_addr));
            wd_q.push_back(int'(write_weight_data));
            wo_q.push_back(ecnt);
        end
        if (done) done_cnt++;
        if (in_ready) ir_cnt++;
        if (in_ready && in_valid) hs_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_start(input logic [15:0] b, input logic [15:0] c);
        base_addr    = b;
        weight_count = c;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        e_start = ecnt;
    endtask

    task automatic send_word(input string tag, input logic [31:0] w, input int gap);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_wr(input string tag, input int idx, input int a, input int d);
        check({tag, "_addr"}, 32'(wa_q[idx]), 32'(a));
        check({tag, "_data"}, 32'(wd_q[idx]), 32'(d));
    endtask

    initial begin
        int w0, d0, h0, i0;
        rst          = 1'b1;
        start        = 1'b0;
        weight_count = 16'd0;
        base_addr    = 16'd0;
        in_valid     = 1'b0;
        in_data      = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_wr", 32'(write_weight_signal), 32'd0);
        check("rst_addr", 32'(write_weight_addr), 32'd0);
        check("rst_data", 32'(write_weight_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        @(posedge clk);
        #1;

        // Basic load: base 0, count 4.
        w0 = wa_q.size(); d0 = done_cnt; h0 = hs_cnt;
        do_start(16'd0, 16'd4);
        @(negedge clk);
        check("basic_fetch_ready", 32'(in_ready), 32'd1);
        check("basic_fetch_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        e_start = e_start + 1;
        send_word("basic_hs0", 32'h0002_0001, 0);
        send_word("basic_hs1", 32'h0004_0003, 0);
        i0 = ir_cnt;
        wait_done("basic_done_seen");
        settle();
        check("basic_nwr", 32'(wa_q.size() - w0), 32'd4);
        if (wa_q.size() - w0 == 4) begin
            check_wr("basic_w0", w0 + 0, 0, 1);
            check_wr("basic_w1", w0 + 1, 1, 2);
            check_wr("basic_w2", w0 + 2, 2, 3);
            check_wr("basic_w3", w0 + 3, 3, 4);
            check("basic_t0", 32'(wo_q[w0 + 0] - e_start + 1), 32'd2);
            check("basic_t1", 32'(wo_q[w0 + 1] - e_start + 1), 32'd3);
            check("basic_t2", 32'(wo_q[w0 + 2] - e_start + 1), 32'd5);
            check("basic_t3", 32'(wo_q[w0 + 3] - e_start + 1), 32'd6);
        end
        check("basic_ndone", 32'(done_cnt - d0), 32'd1);
        check("basic_nhs", 32'(hs_cnt - h0), 32'd2);
        check("basic_ready_after", 32'(ir_cnt - i0), 32'd0);
        check("basic_busy_end", 32'(busy), 32'd0);

        // Odd count with backpressure: base 100, count 3.
        w0 = wa_q.size(); d0 = done_cnt; h0 = hs_cnt;
        do_start(16'd100, 16'd3);
        send_word("odd_hs0", 32'hBBBB_AAAA, 0);
        send_word("odd_hs1", 32'hDDDD_CCCC, 5);
        wait_done("odd_done_seen");
        settle();
        check("odd_nwr", 32'(wa_q.size() - w0), 32'd3);
        if (wa_q.size() - w0 == 3) begin
            check_wr("odd_w0", w0 + 0, 100, 16'hAAAA);
            check_wr("odd_w1", w0 + 1, 101, 16'hBBBB);
            check_wr("odd_w2", w0 + 2, 102, 16'hCCCC);
        end
        check("odd_nhs", 32'(hs_cnt - h0), 32'd2);
        check("odd_ndone", 32'(done_cnt - d0), 32'd1);

        // Range overflow: 8000 + 11 = 8011 > 8010.
        w0 = wa_q.size(); d0 = done_cnt; i0 = ir_cnt;
        do_start(16'd8000, 16'd11);
        @(negedge clk);
        check("ovf_done_t1", 32'(done), 32'd1);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        settle();
        check("ovf_nwr", 32'(wa_q.size() - w0), 32'd0);
        check("ovf_ready", 32'(ir_cnt - i0), 32'd0);
        check("ovf_ndone", 32'(done_cnt - d0), 32'd1);
        check("ovf_error_sticky", 32'(error), 32'd1);

        // Boundary: 8008 + 2 = 8010 is legal; clears the sticky error.
        w0 = wa_q.size();
        do_start(16'd8008, 16'd2);
        @(negedge clk);
        check("bnd_error_clr", 32'(error), 32'd0);
        @(posedge clk);
        #1;
        send_word("bnd_hs0", 32'h2222_1111, 0);
        wait_done("bnd_done_seen");
        settle();
        check("bnd_nwr", 32'(wa_q.size() - w0), 32'd2);
        if (wa_q.size() - w0 == 2) begin
            check_wr("bnd_w0", w0 + 0, 8008, 16'h1111);
            check_wr("bnd_w1", w0 + 1, 8009, 16'h2222);
        end

        // Zero count is rejected.
        w0 = wa_q.size(); i0 = ir_cnt;
        do_start(16'd5, 16'd0);
        @(negedge clk);
        check("zero_error", 32'(error), 32'd1);
        check("zero_done", 32'(done), 32'd1);
        @(posedge clk);
        #1;
        settle();
        check("zero_nwr", 32'(wa_q.size() - w0), 32'd0);
        check("zero_ready", 32'(ir_cnt - i0), 32'd0);

        // Reset during the high-half write abandons the load.
        w0 = wa_q.size(); d0 = done_cnt;
        do_start(16'd0, 16'd4);
        send_word("rstm_hs0", 32'h0002_0001, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstm_wr", 32'(write_weight_signal), 32'd0);
        check("rstm_busy", 32'(busy), 32'd0);
        check("rstm_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        settle();
        check("rstm_ndone", 32'(done_cnt - d0), 32'd0);
        check("rstm_nwr", 32'(wa_q.size() - w0), 32'd2);
        w0 = wa_q.size(); d0 = done_cnt;
        do_start(16'd4, 16'd2);
        send_word("fresh_hs0", 32'h5678_1234, 0);
        wait_done("fresh_done_seen");
        settle();
        check("fresh_nwr", 32'(wa_q.size() - w0), 32'd2);
        if (wa_q.size() - w0 == 2) begin
            check_wr("fresh_w0", w0 + 0, 4, 16'h1234);
            check_wr("fresh_w1", w0 + 1, 5, 16'h5678);
        end
        check("fresh_ndone", 32'(done_cnt - d0), 32'd1);

        // A second start during FETCH is ignored.
        w0 = wa_q.size(); d0 = done_cnt;
        do_start(16'd10, 16'd2);
        do_start(16'd50, 16'd6);
        send_word("busy_hs0", 32'h0202_0101, 0);
        wait_done("busy_done_seen");
        settle();
        settle();
        check("busy_nwr", 32'(wa_q.size() - w0), 32'd2);
        if (wa_q.size() - w0 == 2) begin
            check_wr("busy_w0", w0 + 0, 10, 16'h0101);
            check_wr("busy_w1", w0 + 1, 11, 16'h0202);
        end
        check("busy_ndone", 32'(done_cnt - d0), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
